mac_accum_pipe: RTL and testbench

//   Parametrised, 3-stage pipelined multiply-accumulate engine. Accepts a

---
 rtl/mac_pkg.sv | 59 +++++
 rtl/mac_mult_stage.sv | 72 +++++++
 rtl/mac_accum_pipe.sv | 114 +++++++++++
 tb/tb_mac_accum_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and saturating-add helpers for the pipelined MAC engine.
// Rev 1.0
`default_nettype none

package mac_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [MAX_W-1:0] sum;
    logic             ovf;
  } sat_res_t;

  function automatic logic [MAX_W-1:0] umax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Returned as a w-bit pattern (only the sign bit set).
  function automatic logic [MAX_W-1:0] smin(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // x and y carry w-bit patterns zero-extended to MAX_W; w must be below MAX_W.
  function automatic sat_res_t sat_add(input logic [MAX_W-1:0] x,
                                       input logic [MAX_W-1:0] y,
                                       input int               w,
                                       input bit               sgn,
                                       input bit               sat);
    sat_res_t         r;
    logic [MAX_W-1:0] full;
    logic             sx, sy, ss;
    full  = x + y;
    r.sum = full & umax(w);
    sx    = |(x & smin(w));
    sy    = |(y & smin(w));
    ss    = |(r.sum & smin(w));
    if (sgn) begin
      r.ovf = (sx == sy) && (ss != sx);
      if (r.ovf && sat) r.sum = sx ? smin(w) : smax(w);
    end else begin
      r.ovf = |(full & (64'd1 << w));
      if (r.ovf && sat) r.sum = umax(w);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_mult_stage.sv
// Registered multiplier: S1 captures operands and framing, S2 holds the full-width product.
// Rev 1.0
`default_nettype none

module mac_mult_stage #(
  parameter int DATA_W = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  input  logic                i_clear,
  input  logic                i_last,
  output logic                o_valid,
  output logic                o_clear,
  output logic                o_last,
  output logic [2*DATA_W-1:0] o_prod
);

  localparam int PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0] r_s1_a, r_s1_b;
  logic              r_s1_valid, r_s1_clear, r_s1_last;
  logic [PROD_W-1:0] r_s2_prod;
  logic              r_s2_valid, r_s2_clear, r_s2_last;
  logic [PROD_W-1:0] w_prod;

  // Operands are widened to PROD_W first so the low PROD_W bits are exact.
  generate
    if (SIGNED) begin : g_signed
      assign w_prod = $signed({{DATA_W{r_s1_a[DATA_W-1]}}, r_s1_a}) *
                      $signed({{DATA_W{r_s1_b[DATA_W-1]}}, r_s1_b});
    end else begin : g_unsigned
      assign w_prod = {{DATA_W{1'b0}}, r_s1_a} * {{DATA_W{1'b0}}, r_s1_b};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_clear <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_clear <= 1'b0;
      r_s2_last  <= 1'b0;
    end else if (i_en) begin
      r_s1_a     <= i_a;
      r_s1_b     <= i_b;
      r_s1_valid <= i_valid;
      r_s1_clear <= i_clear;
      r_s1_last  <= i_last;
      r_s2_prod  <= w_prod;
      r_s2_valid <= r_s1_valid;
      r_s2_clear <= r_s1_clear;
      r_s2_last  <= r_s1_last;
    end
  end

  assign o_valid = r_s2_valid;
  assign o_clear = r_s2_clear;
  assign o_last  = r_s2_last;
  assign o_prod  = r_s2_prod;

endmodule

`default_nettype wire

// File: rtl/mac_accum_pipe.sv
// Three-stage pipelined multiply-accumulate engine; one dot-product per clear/last frame.
// Rev 1.0
`default_nettype none

module mac_accum_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              clear,
  input  logic              last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic [CNT_W-1:0]  count
);

  localparam int PROD_W = 2 * DATA_W;

  state_e            r_state, w_state_nxt;
  logic              w_stall, w_s3_fire, w_first;
  logic              w_s2_valid, w_s2_clear, w_s2_last;
  logic [PROD_W-1:0] w_s2_prod;
  logic [MAX_W-1:0]  w_prod64;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  sat_res_t          w_add;
  logic              w_unused;

  mac_mult_stage #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (!w_stall),
    .i_valid (in_valid && in_ready),
    .i_a     (a),
    .i_b     (b),
    .i_clear (clear),
    .i_last  (last),
    .o_valid (w_s2_valid),
    .o_clear (w_s2_clear),
    .o_last  (w_s2_last),
    .o_prod  (w_s2_prod)
  );

  assign w_prod64 = {{(MAX_W-PROD_W){SIGNED && w_s2_prod[PROD_W-1]}}, w_s2_prod};
  assign w_add    = sat_add({{(MAX_W-ACC_W){1'b0}}, r_acc},
                            {{(MAX_W-ACC_W){1'b0}}, w_prod64[ACC_W-1:0]},
                            ACC_W, SIGNED, SAT_EN);
  assign w_unused = ^{w_add.sum[MAX_W-1:ACC_W], w_prod64[MAX_W-1:ACC_W]};
  assign w_s3_fire = w_s2_valid && !w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // DONE hands straight to ACC/DONE when a beat lands in the handshake cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_s3_fire) w_state_nxt = w_s2_last ? DONE : ACC;
      ACC:     if (w_s3_fire && w_s2_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = w_s3_fire ? (w_s2_last ? DONE : ACC) : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == DONE);
    w_stall   = out_valid && !out_ready;
    in_ready  = !w_stall;
    w_first   = (r_state != ACC) || w_s2_clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_s3_fire) begin
      if (w_first) begin
        r_acc   <= w_prod64[ACC_W-1:0];
        r_count <= {{(CNT_W-1){1'b0}}, 1'b1};
        r_ovf   <= 1'b0;
      end else begin
        r_acc <= w_add.sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_add.ovf;
        if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
      end
    end
  end

  assign result   = r_acc;
  assign overflow = r_ovf;
  assign count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mac_accum_pipe.sv
// Directed self-checking bench: default, signed, saturating and wrapping instances share one stimulus.
// Rev 1.0
`default_nettype none

module tb_mac_accum_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       clear = 1'b0;
  logic       last = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        ov0, ov1, ov2, ov3;
  logic        ovf0, ovf1, ovf2, ovf3;
  logic [23:0] res0, res1;
  logic [15:0] res2, res3;
  logic [7:0]  cnt0, cnt1, cnt2, cnt3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mac_accum_pipe u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
    .clear(clear), .last(last), .out_valid(ov0), .out_ready(out_ready),
    .result(res0), .overflow(ovf0), .count(cnt0));

  mac_accum_pipe #(.SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
    .clear(clear), .last(last), .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .overflow(ovf1), .count(cnt1));

  mac_accum_pipe #(.ACC_W(16), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .a(a), .b(b),
    .clear(clear), .last(last), .out_valid(ov2), .out_ready(out_ready),
    .result(res2), .overflow(ovf2), .count(cnt2));

  mac_accum_pipe #(.ACC_W(16), .SAT_EN(1'b0)) u_wrp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .a(a), .b(b),
    .clear(clear), .last(last), .out_valid(ov3), .out_ready(out_ready),
    .result(res3), .overflow(ovf3), .count(cnt3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic beat(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic il);
    a = ia; b = ib; clear = ic; last = il; in_valid = 1'b1;
    for (int k = 0; k < 50 && !rdy0; k++) @(negedge clk);
    if (!rdy0) chk("in_ready_timeout", {63'd0, rdy0}, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_out(input string tag);
    for (int k = 0; k < 50 && !ov0; k++) @(negedge clk);
    chk(tag, {63'd0, ov0}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, ov0}, 64'd0);
    chk("rst_in_ready",  {63'd0, rdy0}, 64'd1);
    chk("rst_result",    64'(res0), 64'd0);
    chk("rst_count",     64'(cnt0), 64'd0);
    chk("rst_overflow",  {63'd0, ovf0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-term frame and last-to-out_valid latency.
    beat(8'd3, 8'd4, 1'b1, 1'b0);
    beat(8'd5, 8'd6, 1'b0, 1'b0);
    beat(8'd7, 8'd8, 1'b0, 1'b1);
    in_valid = 1'b0;
    chk("t1_lat1", {63'd0, ov0}, 64'd0);
    @(negedge clk);
    chk("t1_lat2", {63'd0, ov0}, 64'd0);
    @(negedge clk);
    chk("t1_lat3", {63'd0, ov0}, 64'd1);
    chk("t1_result", 64'(res0), 64'd98);
    chk("t1_count",  64'(cnt0), 64'd3);
    chk("t1_ovf",    {63'd0, ovf0}, 64'd0);
    chk("t1_sgn_result", 64'(res1), 64'd98);
    @(negedge clk);
    chk("t1_ack", {63'd0, ov0}, 64'd0);

    // Back-to-back single-beat frames with no bubble.
    beat(8'd255, 8'd255, 1'b1, 1'b1);
    beat(8'd2, 8'd3, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_valid_a",  {63'd0, ov0}, 64'd1);
    chk("t2_result_a", 64'(res0), 64'd65025);
    chk("t2_count_a",  64'(cnt0), 64'd1);
    @(negedge clk);
    chk("t2_valid_b",  {63'd0, ov0}, 64'd1);
    chk("t2_result_b", 64'(res0), 64'd6);
    chk("t2_count_b",  64'(cnt0), 64'd1);
    @(negedge clk);

    // Signed instance.
    beat(8'h80, 8'h80, 1'b1, 1'b0);
    beat(8'h80, 8'h80, 1'b0, 1'b0);
    beat(8'h80, 8'h80, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_out("t3a_valid");
    chk("t3a_sgn_result", 64'(res1), 64'd49152);
    chk("t3a_sgn_ovf",    {63'd0, ovf1}, 64'd0);
    @(negedge clk);
    beat(8'hFD, 8'd5, 1'b1, 1'b0);
    beat(8'd2, 8'd1, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_out("t3b_valid");
    chk("t3b_sgn_result", 64'(res1), 64'h0000_0000_00FF_FFF3);
    chk("t3b_sgn_count",  64'(cnt1), 64'd2);
    chk("t3b_sgn_ovf",    {63'd0, ovf1}, 64'd0);
    @(negedge clk);

    // 16-bit accumulators: saturate vs wrap; 24-bit holds the true sum.
    beat(8'd255, 8'd255, 1'b1, 1'b0);
    beat(8'd255, 8'd255, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_out("t4_valid");
    chk("t4_sat_result", 64'(res2), 64'hFFFF);
    chk("t4_sat_ovf",    {63'd0, ovf2}, 64'd1);
    chk("t4_wrp_result", 64'(res3), 64'hFC02);
    chk("t4_wrp_ovf",    {63'd0, ovf3}, 64'd1);
    chk("t4_def_result", 64'(res0), 64'd130050);
    chk("t4_def_ovf",    {63'd0, ovf0}, 64'd0);
    @(negedge clk);

    // Backpressure: result held, input blocked, pending beat not lost.
    out_ready = 1'b0;
    beat(8'd1, 8'd2, 1'b1, 1'b0);
    beat(8'd3, 8'd4, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_out("t5_valid");
    a = 8'd5; b = 8'd5; clear = 1'b1; last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_in_ready", {63'd0, rdy0}, 64'd0);
      chk("t5_hold_vld", {63'd0, ov0}, 64'd1);
      chk("t5_hold_res", 64'(res0), 64'd14);
      chk("t5_hold_cnt", 64'(cnt0), 64'd2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_ack", {63'd0, ov0}, 64'd0);
    wait_out("t5_next_valid");
    chk("t5_next_res", 64'(res0), 64'd25);
    chk("t5_next_cnt", 64'(cnt0), 64'd1);
    @(negedge clk);

    // Reset mid-frame.
    beat(8'd10, 8'd10, 1'b1, 1'b0);
    beat(8'd1, 8'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {63'd0, ov0}, 64'd0);
    chk("t6_rst_res",   64'(res0), 64'd0);
    chk("t6_rst_cnt",   64'(cnt0), 64'd0);
    chk("t6_rst_ovf",   {63'd0, ovf0}, 64'd0);
    chk("t6_rst_rdy",   {63'd0, rdy0}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(8'd2, 8'd2, 1'b0, 1'b0);
    beat(8'd3, 8'd3, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_out("t6_valid");
    chk("t6_result", 64'(res0), 64'd13);
    chk("t6_count",  64'(cnt0), 64'd2);
    @(negedge clk);

    // 260-term frame: count saturates at 255, sum keeps going.
    beat(8'd1, 8'd1, 1'b1, 1'b0);
    for (int i = 0; i < 258; i++) beat(8'd1, 8'd1, 1'b0, 1'b0);
    beat(8'd1, 8'd1, 1'b0, 1'b1);
    in_valid = 1'b0;
    wait_out("t7_valid");
    chk("t7_result", 64'(res0), 64'd260);
    chk("t7_count",  64'(cnt0), 64'd255);
    chk("t7_ovf",    {63'd0, ovf0}, 64'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
